// File: rtl/vram_cpu_pkg.sv
// ----------------------------------------------------------------------------
// vram_cpu_pkg
// Shared types and constants for the CPU-side VRAM port.
//   state_t     : CPU port sequencer states (IDLE / ARM / BUSY)
//   wr_entry_t  : one posted write, {addr, data}
//   VRAM_AW     : default physical address width
//   ptr_w()     : pointer width for a FIFO of a given depth (never 0)
//   make_entry(): packs an address/data pair into a wr_entry_t
// ----------------------------------------------------------------------------
package vram_cpu_pkg;

    localparam int VRAM_AW = 19;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        BUSY = 2'd2
    } state_t;

    typedef struct packed {
        logic [VRAM_AW-1:0] addr;
        logic [7:0]         data;
    } wr_entry_t;

    // A depth-1 FIFO still gets a 1-bit pointer so no vector collapses to zero width.
    function automatic int ptr_w(input int depth);
        if (depth > 1) begin
            return $clog2(depth);
        end else begin
            return 1;
        end
    endfunction

    function automatic wr_entry_t make_entry(input logic [VRAM_AW-1:0] addr,
                                             input logic [7:0]         data);
        wr_entry_t e;
        e.addr = addr;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// ----------------------------------------------------------------------------
// vram_wr_fifo
// Synchronous FIFO holding posted CPU writes. Push and pop may occur in the
// same cycle (count unchanged). A push while full is accepted only if a pop
// happens in the same cycle.
// Ports:
//   clk_sys, reset      : clock, synchronous active-high reset
//   push, push_entry    : write request and entry
//   pop                 : remove the head entry
//   head                : current head entry (valid when !empty)
//   full, empty, count  : occupancy; count is one bit wider than the pointers
// ----------------------------------------------------------------------------
module vram_wr_fifo
    import vram_cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  push,
    input  wr_entry_t             push_entry,
    input  logic                  pop,
    output wr_entry_t             head,
    output logic                  full,
    output logic                  empty,
    output logic [ptr_w(DEPTH):0] count
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    wr_entry_t       mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            do_push_s;
    logic            do_pop_s;

    // Pointers wrap modulo DEPTH rather than relying on natural overflow.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == LAST_PTR) begin
            return PW'(0);
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Occupancy flags and qualified push/pop strobes.
    always_comb begin
        full      = (count_r == FULL_CNT);
        empty     = (count_r == CW'(0));
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
        head      = mem_r[rd_ptr_r];
        count     = count_r;
    end

    // Storage, pointers and occupancy counter.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_entry;
                wr_ptr_r        <= next_ptr(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/vram_cpu_port.sv
// ----------------------------------------------------------------------------
// vram_cpu_port
// CPU-side reader/writer for the shared VRAM. Writes are posted through a
// small FIFO; a write that finds the FIFO full is parked in a hold register
// and stalls the CPU until a slot frees up. Reads stall the CPU and are issued
// only after every older write has reached RAM (strict program order, no
// forwarding). Accesses go out only in slots the video side does not own.
// Ports:
//   clk_sys, reset        : clock, synchronous active-high reset
//   ce_6mn, mem_contention: slot strobe and video ownership of the slot
//   cpu_req/we/addr/din   : Z80 memory cycle (level request, paged address)
//   cpu_dout, cpu_wait    : read data and wait request back to the CPU
//   ram_req/we/addr/din   : one-cycle access strobe and held access fields
//   ram_ack, ram_dout     : one-cycle completion and read data
// All outputs are registered.
// ----------------------------------------------------------------------------
module vram_cpu_port
    import vram_cpu_pkg::*;
#(
    parameter int AW       = VRAM_AW,
    parameter int WR_DEPTH = 2
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ce_6mn,
    input  logic          mem_contention,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_wait,
    output logic          ram_req,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    input  logic          ram_ack,
    input  logic [7:0]    ram_dout
);

    localparam int CW = ptr_w(WR_DEPTH) + 1;

    // Sequencer and output registers
    state_t          state_r;
    state_t          state_nx_s;
    logic            ram_req_r;
    logic            ram_we_r;
    logic [AW-1:0]   ram_addr_r;
    logic [7:0]      ram_din_r;
    logic            ram_req_nx_s;
    logic            ram_we_nx_s;
    logic [AW-1:0]   ram_addr_nx_s;
    logic [7:0]      ram_din_nx_s;
    logic [7:0]      cpu_dout_r;
    logic            cpu_wait_r;

    // CPU request tracking
    logic            req_d_r;
    logic            hold_valid_r;
    wr_entry_t       hold_entry_r;
    logic            rd_pend_r;
    logic [AW-1:0]   rd_addr_r;

    // Decoded events
    logic            edge_s;
    logic            wr_edge_s;
    logic            rd_edge_s;
    logic            slot_s;
    logic            ack_ok_s;
    logic            pop_s;
    logic            rd_done_s;
    logic            hold_push_s;
    logic            edge_push_s;
    logic            hold_set_s;
    logic            push_s;
    logic            work_s;
    logic            left_s;
    wr_entry_t       push_entry_s;

    // FIFO view
    wr_entry_t       head_s;
    logic            full_s;
    logic            empty_s;
    logic [CW-1:0]   count_s;

    vram_wr_fifo #(
        .DEPTH (WR_DEPTH)
    ) u_fifo (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .head       (head_s),
        .full       (full_s),
        .empty      (empty_s),
        .count      (count_s)
    );

    // Request edge decode and FIFO push/pop steering.
    always_comb begin
        // A new edge is ignored while a blocked operation is still parked:
        // that only happens after a CPU abort, and the parked op must finish.
        edge_s      = cpu_req & ~req_d_r & ~hold_valid_r & ~rd_pend_r;
        wr_edge_s   = edge_s & cpu_we;
        rd_edge_s   = edge_s & ~cpu_we;
        slot_s      = ce_6mn & ~mem_contention;
        // The ram_req cycle itself never counts as an acknowledge.
        ack_ok_s    = (state_r == BUSY) & ~ram_req_r & ram_ack;
        pop_s       = ack_ok_s & ram_we_r;
        rd_done_s   = ack_ok_s & ~ram_we_r;
        hold_push_s = hold_valid_r & ~full_s;
        edge_push_s = wr_edge_s & ~full_s;
        hold_set_s  = wr_edge_s & full_s;
        push_s      = hold_push_s | edge_push_s;
        if (hold_valid_r) begin
            push_entry_s = hold_entry_r;
        end else begin
            push_entry_s = make_entry(VRAM_AW'(cpu_addr), cpu_din);
        end
    end

    // Sequencer next state and next RAM port fields.
    always_comb begin
        state_nx_s    = state_r;
        ram_req_nx_s  = 1'b0;
        ram_we_nx_s   = ram_we_r;
        ram_addr_nx_s = ram_addr_r;
        ram_din_nx_s  = ram_din_r;
        work_s        = ~empty_s | hold_valid_r | rd_pend_r;
        // Work still outstanding once this cycle's ack/push/edge has landed.
        if (pop_s) begin
            left_s = (count_s > CW'(1));
        end else begin
            left_s = ~empty_s;
        end
        left_s = left_s | push_s | hold_valid_r | hold_set_s | rd_edge_s
                 | (rd_pend_r & ~rd_done_s);

        case (state_r)
            IDLE: begin
                if (work_s) begin
                    state_nx_s = ARM;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ARM: begin
                if (slot_s & ~empty_s) begin
                    ram_req_nx_s  = 1'b1;
                    ram_we_nx_s   = 1'b1;
                    ram_addr_nx_s = AW'(head_s.addr);
                    ram_din_nx_s  = head_s.data;
                    state_nx_s    = BUSY;
                end else if (slot_s & rd_pend_r & ~hold_valid_r) begin
                    ram_req_nx_s  = 1'b1;
                    ram_we_nx_s   = 1'b0;
                    ram_addr_nx_s = rd_addr_r;
                    state_nx_s    = BUSY;
                end else if (~work_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = ARM;
                end
            end
            BUSY: begin
                if (ack_ok_s) begin
                    if (left_s) begin
                        state_nx_s = ARM;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end else begin
                    state_nx_s = BUSY;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // RAM port output registers; fields hold between requests.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ram_req_r  <= 1'b0;
            ram_we_r   <= 1'b0;
            ram_addr_r <= AW'(0);
            ram_din_r  <= 8'h00;
        end else begin
            ram_req_r  <= ram_req_nx_s;
            ram_we_r   <= ram_we_nx_s;
            ram_addr_r <= ram_addr_nx_s;
            ram_din_r  <= ram_din_nx_s;
        end
    end

    // CPU request edge history, blocked-write hold register and pending read.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            req_d_r      <= 1'b0;
            hold_valid_r <= 1'b0;
            hold_entry_r <= '0;
            rd_pend_r    <= 1'b0;
            rd_addr_r    <= AW'(0);
        end else begin
            req_d_r <= cpu_req;
            if (hold_set_s) begin
                hold_valid_r <= 1'b1;
                hold_entry_r <= push_entry_s;
            end else if (hold_push_s) begin
                hold_valid_r <= 1'b0;
            end
            if (rd_edge_s) begin
                rd_pend_r <= 1'b1;
                rd_addr_r <= cpu_addr;
            end else if (rd_done_s) begin
                rd_pend_r <= 1'b0;
            end
        end
    end

    // CPU-facing read data and wait request.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cpu_dout_r <= 8'h00;
            cpu_wait_r <= 1'b0;
        end else begin
            if (rd_done_s) begin
                cpu_dout_r <= ram_dout;
            end
            // Releasing on the pop lets the parked write push in the very
            // cycle the CPU sees wait drop.
            if (rd_done_s) begin
                cpu_wait_r <= 1'b0;
            end else if (pop_s & hold_valid_r) begin
                cpu_wait_r <= 1'b0;
            end else if (hold_push_s) begin
                cpu_wait_r <= 1'b0;
            end else if (hold_set_s | rd_edge_s) begin
                cpu_wait_r <= 1'b1;
            end
        end
    end

    assign cpu_dout = cpu_dout_r;
    assign cpu_wait = cpu_wait_r;
    assign ram_req  = ram_req_r;
    assign ram_we   = ram_we_r;
    assign ram_addr = ram_addr_r;
    assign ram_din  = ram_din_r;

endmodule

// File: tb/tb_vram_cpu_port.sv
// ----------------------------------------------------------------------------
// tb_vram_cpu_port
// Directed bench for vram_cpu_port: single write, contended read, FIFO
// overflow into the hold register, write-then-read ordering, push coinciding
// with pop, and reset in the middle of an access with a late acknowledge.
// A tiny associative-array RAM model answers accesses from the bench.
// ----------------------------------------------------------------------------
module tb_vram_cpu_port;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ce_6mn;
    logic        mem_contention;
    logic        cpu_req;
    logic        cpu_we;
    logic [18:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_wait;
    logic        ram_req;
    logic        ram_we;
    logic [18:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_ack;
    logic [7:0]  ram_dout;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [7:0]  mem [int];

    always #5 clk_sys = ~clk_sys;

    vram_cpu_port #(
        .AW       (19),
        .WR_DEPTH (2)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ce_6mn         (ce_6mn),
        .mem_contention (mem_contention),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_din        (cpu_din),
        .cpu_dout       (cpu_dout),
        .cpu_wait       (cpu_wait),
        .ram_req        (ram_req),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_din        (ram_din),
        .ram_ack        (ram_ack),
        .ram_dout       (ram_dout)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_edge(input logic we, input logic [18:0] a, input logic [7:0] d);
        cpu_req  = 1'b1;
        cpu_we   = we;
        cpu_addr = a;
        cpu_din  = d;
        tick();
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (ram_req !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        chk({tag, "_req_seen"}, 32'(ram_req), 32'd1);
    endtask

    // Waits for an access, checks its fields, then acks it one cycle later.
    task automatic ram_service(input string tag, input logic exp_we,
                               input logic [18:0] exp_addr, input logic [7:0] exp_din);
        logic [7:0] rdata;
        wait_req(tag);
        chk({tag, "_we"},   32'(ram_we),   32'(exp_we));
        chk({tag, "_addr"}, 32'(ram_addr), 32'(exp_addr));
        if (exp_we) begin
            chk({tag, "_din"}, 32'(ram_din), 32'(exp_din));
            mem[int'(ram_addr)] = ram_din;
        end
        if (mem.exists(int'(ram_addr))) begin
            rdata = mem[int'(ram_addr)];
        end else begin
            rdata = 8'h00;
        end
        tick();
        chk({tag, "_req_1cyc"},  32'(ram_req),  32'd0);
        chk({tag, "_addr_hold"}, 32'(ram_addr), 32'(exp_addr));
        ram_ack  = 1'b1;
        ram_dout = rdata;
        tick();
        ram_ack  = 1'b0;
        ram_dout = 8'h00;
    endtask

    initial begin
        reset = 1'b1; ce_6mn = 1'b1; mem_contention = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 19'h0; cpu_din = 8'h00;
        ram_ack = 1'b0; ram_dout = 8'h00;
        mem[32'h100] = 8'h5A;
        repeat (3) tick();

        // Reset state
        chk("rst_cpu_dout", 32'(cpu_dout), 32'd0);
        chk("rst_cpu_wait", 32'(cpu_wait), 32'd0);
        chk("rst_ram_req",  32'(ram_req),  32'd0);
        chk("rst_ram_we",   32'(ram_we),   32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_din",  32'(ram_din),  32'd0);
        chk("rst_count",    32'(dut.count_s), 32'd0);
        reset = 1'b0;
        tick();

        // Single uncontended write
        cpu_edge(1'b1, 19'h12345, 8'hA5);
        chk("w1_no_wait", 32'(cpu_wait), 32'd0);
        cpu_req = 1'b0;
        ram_service("w1", 1'b1, 19'h12345, 8'hA5);
        chk("w1_fifo_empty", 32'(dut.count_s), 32'd0);
        chk("w1_no_wait_end", 32'(cpu_wait), 32'd0);

        // Read with three contended strobes before a free one
        ce_6mn = 1'b0; mem_contention = 1'b1;
        cpu_edge(1'b0, 19'h00100, 8'h00);
        chk("rd_wait_rise", 32'(cpu_wait), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            for (int j = 0; j < 3; j++) begin
                tick();
                chk($sformatf("rd_gap%0d_%0d", k, j), 32'(ram_req), 32'd0);
            end
            ce_6mn = 1'b1;
            mem_contention = (k < 4) ? 1'b1 : 1'b0;
            tick();
            ce_6mn = 1'b0;
            chk($sformatf("rd_strobe%0d", k), 32'(ram_req), 32'(k == 4));
        end
        chk("rd_wait_held", 32'(cpu_wait), 32'd1);
        ram_service("rd", 1'b0, 19'h00100, 8'h00);
        chk("rd_dout", 32'(cpu_dout), 32'h5A);
        chk("rd_wait_drop", 32'(cpu_wait), 32'd0);
        cpu_req = 1'b0;
        tick();

        // Three back-to-back writes against a held-off RAM port
        ce_6mn = 1'b1; mem_contention = 1'b1;
        cpu_edge(1'b1, 19'h00001, 8'h01);
        chk("bb_w1_no_wait", 32'(cpu_wait), 32'd0);
        cpu_req = 1'b0; tick();
        cpu_edge(1'b1, 19'h00002, 8'h02);
        chk("bb_w2_no_wait", 32'(cpu_wait), 32'd0);
        chk("bb_full", 32'(dut.count_s), 32'd2);
        cpu_req = 1'b0; tick();
        cpu_edge(1'b1, 19'h00003, 8'h03);
        chk("bb_w3_wait", 32'(cpu_wait), 32'd1);
        tick(); tick();
        chk("bb_w3_wait_held", 32'(cpu_wait), 32'd1);
        chk("bb_no_req", 32'(ram_req), 32'd0);
        mem_contention = 1'b0;
        ram_service("bb1", 1'b1, 19'h00001, 8'h01);
        chk("bb_wait_drop", 32'(cpu_wait), 32'd0);
        chk("bb_after_pop", 32'(dut.count_s), 32'd1);
        cpu_req = 1'b0;
        tick();
        chk("bb_hold_pushed", 32'(dut.count_s), 32'd2);
        ram_service("bb2", 1'b1, 19'h00002, 8'h02);
        ram_service("bb3", 1'b1, 19'h00003, 8'h03);
        chk("bb_drained", 32'(dut.count_s), 32'd0);
        tick();

        // Write then read of the same address: read goes out after the write
        cpu_edge(1'b1, 19'h00010, 8'h11);
        cpu_req = 1'b0; tick();
        cpu_edge(1'b0, 19'h00010, 8'h00);
        chk("wr_rd_wait", 32'(cpu_wait), 32'd1);
        ram_service("wr_rd_w", 1'b1, 19'h00010, 8'h11);
        chk("wr_rd_still_wait", 32'(cpu_wait), 32'd1);
        ram_service("wr_rd_r", 1'b0, 19'h00010, 8'h00);
        chk("wr_rd_dout", 32'(cpu_dout), 32'h11);
        chk("wr_rd_wait_drop", 32'(cpu_wait), 32'd0);
        cpu_req = 1'b0;
        tick();

        // Edge push in the same cycle as an ack pop at count 1
        mem_contention = 1'b1;
        cpu_edge(1'b1, 19'h00020, 8'h20);
        cpu_req = 1'b0; tick();
        mem_contention = 1'b0;
        wait_req("pp_a");
        chk("pp_a_addr", 32'(ram_addr), 32'h20);
        tick();
        ram_ack = 1'b1; ram_dout = 8'h00;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00021; cpu_din = 8'h21;
        tick();
        ram_ack = 1'b0; cpu_req = 1'b0;
        chk("pp_count", 32'(dut.count_s), 32'd1);
        chk("pp_no_wait", 32'(cpu_wait), 32'd0);
        ram_service("pp_b", 1'b1, 19'h00021, 8'h21);
        chk("pp_drained", 32'(dut.count_s), 32'd0);
        tick();

        // Reset while BUSY, followed by a late acknowledge
        cpu_edge(1'b0, 19'h00030, 8'h00);
        wait_req("rs");
        chk("rs_we", 32'(ram_we), 32'd0);
        tick();
        reset = 1'b1; cpu_req = 1'b0;
        tick();
        chk("rs_ram_req", 32'(ram_req), 32'd0);
        chk("rs_cpu_wait", 32'(cpu_wait), 32'd0);
        chk("rs_cpu_dout", 32'(cpu_dout), 32'd0);
        reset = 1'b0;
        ram_ack = 1'b1; ram_dout = 8'hFF;
        tick();
        ram_ack = 1'b0; ram_dout = 8'h00;
        tick();
        chk("rs_late_dout", 32'(cpu_dout), 32'd0);
        chk("rs_late_wait", 32'(cpu_wait), 32'd0);
        chk("rs_late_req", 32'(ram_req), 32'd0);
        chk("rs_count", 32'(dut.count_s), 32'd0);
        repeat (4) tick();
        chk("rs_quiet_req", 32'(ram_req), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vram_cpu_port.md
Name: vram_cpu_port

Overview:
- CPU-side writer/reader for the shared VRAM. The video controller is the other port and reads VRAM on its fetch slots.
- Takes Z80 memory cycles, which are already paged to 19-bit physical addresses. It issues them to the RAM port only in slots where mem_contention is low, and drives cpu_wait until a read completes or a blocked write is accepted.
- Writes are posted through a small FIFO, so uncontended write cycles cost the CPU nothing.

Parameters:
- AW, 19, physical address width.
- WR_DEPTH, 2, posted-write FIFO depth (power of 2, ≥1).

Ports:
- clk_sys  in  1  master clock
- reset  in  1  synchronous, active-high
- ce_6mn  in  1  slot strobe, shared with the video controller
- mem_contention  in  1  from video controller; high = slot owned by video
- cpu_req  in  1  level; high while a CPU memory cycle (MREQ & (RD|WR)) is active
- cpu_we  in  1  1 = write, 0 = read; valid while cpu_req is high
- cpu_addr  in  AW  physical address
- cpu_din  in  8  write data from CPU
- cpu_dout  out  8  read data to CPU
- cpu_wait  out  1  CPU wait request
- ram_req  out  1  one-cycle access strobe
- ram_we  out  1  write qualifier for ram_req
- ram_addr  out  AW  access address
- ram_din  out  8  write data
- ram_ack  in  1  one-cycle completion from the RAM controller
- ram_dout  in  8  read data, valid with ram_ack

Behaviour:
- Reset values: all outputs 0. FIFO empty, state IDLE, req_d=0.
- Request detection: req_d <= cpu_req. A new cycle starts on cpu_req & ~req_d (the edge). Only one cycle is accepted per edge.
- Write on an edge:
  - FIFO not full: push {addr,data} that cycle; cpu_wait stays 0.
  - FIFO full: latch the write into a hold register and raise cpu_wait from the next cycle. The push happens the cycle after the first pop; cpu_wait drops in that same cycle.
- Read on an edge:
  - Latch the address into rd_pend; cpu_wait rises the next cycle.
  - The read is issued only after the FIFO and hold register are empty. This gives strict program order; there is no forwarding.
- Slot: slot = ce_6mn & ~mem_contention. Nothing is issued outside a slot.
- State machine:
  - IDLE → ARM when the FIFO is non-empty or rd_pend is set.
  - ARM: on slot, pulse ram_req=1 for one cycle. Source is the FIFO head (ram_we=1) if non-empty, else rd_pend (ram_we=0). Drive ram_addr/ram_din; go to BUSY.
  - BUSY: wait for ram_ack. ram_ack is not sampled in the ram_req cycle.
    - On ack of a write: pop the FIFO.
    - On ack of a read: cpu_dout <= ram_dout, clear rd_pend, drop cpu_wait the cycle after ack.
    - Then go to ARM if work remains, else IDLE.
- Held values: ram_addr/ram_we/ram_din hold from the ram_req cycle until ack. cpu_dout holds until the next read completes.
- Simultaneous events:
  - Edge-push in the same cycle as an ack-pop: both happen; count unchanged.
  - A read edge while writes are queued: the read waits behind them.
- cpu_req falling while cpu_wait=1 (CPU reset/abort): an accepted operation still completes; a read result is still latched.
- ram_ack in IDLE/ARM: ignored. No timeout.
- Reset mid-operation: FIFO, hold register and rd_pend cleared; state IDLE; ram_req=0, cpu_wait=0 the next cycle. A late ram_ack is ignored.
- FIFO pointers are log2(WR_DEPTH)-bit, wrap modulo WR_DEPTH. The count is one bit wider, so full = count==WR_DEPTH.

Decomposition:
- Package vram_cpu_pkg:
  - state enum {IDLE, ARM, BUSY}
  - wr_entry_t struct {addr[AW], data[8]}
  - AW default constant
- Sub-module vram_wr_fifo: synchronous FIFO of wr_entry_t with push/pop/full/empty. Simultaneous push and pop are allowed.

Test Plan:
- Single write 0x12345 = 0xA5, mem_contention=0 → no cpu_wait; one ram_req, ram_we=1, addr 0x12345, din 0xA5 at the first ce_6mn; FIFO empty after ack.
- Read 0x00100, mem_contention high for 3 ce_6mn strobes, RAM returns 0x5A → cpu_wait rises the cycle after the edge; ram_req only on the 4th strobe; cpu_dout=0x5A and cpu_wait=0 the cycle after ack.
- Three back-to-back writes, WR_DEPTH=2, contention held high → first two posted with no wait; third asserts cpu_wait until the first pop, then cpu_wait=0.
- Write 0x00010=0x11 then read 0x00010 → write issued and acked before the read's ram_req; cpu_dout=0x11 (from the RAM model).
- Edge-push coinciding with an ack-pop at count=1 → count stays 1; entry order preserved.
- Reset asserted in BUSY with a late ram_ack → ram_req=0, cpu_wait=0 after reset; ack ignored; cpu_dout=0.
